wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two sources: in-order execute-stage retirements (ALU result or PC+4 link) and in-order load responses from data memory with variable latency.
- Drives the writeback mux select (0=mem, 1=alu, 2=pc), the register-file write enable and the write address.
- Tracks outstanding loads in an in-order FIFO of destination registers.
- Stalls the execute stage on port conflict, WAW hazard against a pending load, or a full load FIFO.

Parameters:
DEPTH, 4, max outstanding loads (power of 2, >=2)
AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  execute stage presents an instruction
ex_src  in  2  0=load issue, 1=alu writeback, 2=pc writeback, 3=no writeback (store/branch)
ex_rd  in  AW  destination register of ex instruction
ex_ready  out  1  instruction accepted this cycle (handshake = ex_valid & ex_ready)
mem_rvalid  in  1  load data valid this cycle (in order, cannot be back-pressured)
wb_select  out  2  writeback mux select
rf_we  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
pending  out  $clog2(DEPTH)+1  outstanding-load count
wb_err  out  1  sticky: mem_rvalid received with no pending load
perf_stalls  out  32  stall-cycle counter (see Optional Feature)
perf_loads  out  32  completed-load counter (see Optional Feature)

Behaviour:
- Reset (async, active-high): FIFO pointers and count = 0, wb_err = 0, perf counters = 0.
- Outputs are combinational from current state and inputs: 0-cycle latency from accept/response to rf_we.
- While reset is high: ex_ready = 0, rf_we = 0, wb_select = 2'd1, rf_waddr = 0.
- Pop: mem_rvalid & count>0.
  - wb_select = 0, rf_waddr = FIFO head rd, rf_we = (head rd != 0); pop the head.
  - Memory always wins the port.
- mem_rvalid & count==0: set wb_err, rf_we = 0, no pointer change.
- ex_ready conditions:
  - ex_src 1/2: !mem_rvalid & no WAW.
  - ex_src 0: count<DEPTH, or pop in the same cycle.
  - ex_src 3: always 1.
- WAW hazard: ex_src in {1,2}, ex_rd != 0, and ex_rd equals the rd of any valid FIFO entry.
- Accepted ex_src 1/2: wb_select = ex_src, rf_waddr = ex_rd, rf_we = (ex_rd != 0).
- Accepted load: push ex_rd (including x0) at the tail; rf_we is not driven by the push itself.
- Push and pop in the same cycle:
  - count unchanged, both pointers advance.
  - Allowed when full.
  - When empty, the pop is an error; the push still happens.
- Pointers wrap modulo DEPTH; count saturates logically at DEPTH (push is refused when full without a pop).
- Idle (no pop, no accepted 1/2): rf_we = 0, wb_select = 1, rf_waddr = 0.
- ex_ready may be high while ex_valid is low; state changes only on the handshake.
- Reset mid-operation drops all pending entries. Late responses after reset set wb_err.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- Defined:
  - perf_stalls increments on every cycle with ex_valid & !ex_ready.
  - perf_loads increments on every valid pop.
  - Both counters wrap at 2^32.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- ALU writeback: ex_valid=1, ex_src=1, ex_rd=5, no pending -> ex_ready=1, rf_we=1, wb_select=1, rf_waddr=5.
- Port conflict: one pending load rd=3, mem_rvalid=1 with ex_src=2, ex_rd=7 -> wb_select=0, rf_waddr=3, ex_ready=0; next cycle (no rvalid) -> wb_select=2, rf_waddr=7, ex_ready=1.
- WAW: load to rd=9 pending, ex_src=1, ex_rd=9 -> ex_ready=0 until response pops rd=9; then accepted next cycle.
- Full FIFO (DEPTH=4): issue 4 loads -> pending=4; 5th load with no rvalid -> ex_ready=0; 5th load with mem_rvalid=1 -> ex_ready=1, pending stays 4; responses retire rds in issue order.
- x0 and error: load rd=0 then response -> rf_we=0, pending 1->0; extra mem_rvalid -> wb_err=1, stays 1 until reset.
- Perf (WB_ARB_PERF_EN defined): 3 stalled cycles and 2 load responses -> perf_stalls=3, perf_loads=2; async reset mid-run -> both 0, pending=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Shares the single register-file write port between in-order
//             execute-stage retirements (ALU result / PC+4 link) and in-order
//             load responses from data memory. Outstanding load destinations
//             are held in an in-order FIFO. The execute stage is stalled on a
//             port conflict, on a WAW hazard against a pending load, or when
//             the load FIFO is full.
//  Ports    : clk, reset     - clock (rising edge), async active-high reset
//             ex_valid/ex_src/ex_rd/ex_ready - execute-stage handshake
//                              (ex_src 0=load, 1=alu, 2=pc, 3=no writeback)
//             mem_rvalid     - load response this cycle (never back-pressured)
//             wb_select      - writeback mux select (0=mem, 1=alu, 2=pc)
//             rf_we/rf_waddr - register-file write port
//             pending        - outstanding-load count
//             wb_err         - sticky: response arrived with nothing pending
//             perf_stalls/perf_loads - performance counters
//  Options  : WB_ARB_PERF_EN - when defined, perf_stalls counts cycles with
//             ex_valid & !ex_ready and perf_loads counts popped loads (both
//             wrap at 2^32); when undefined both ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  input  logic [1:0]               ex_src,
  input  logic [AW-1:0]            ex_rd,
  output logic                     ex_ready,
  input  logic                     mem_rvalid,
  output logic [1:0]               wb_select,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     wb_err,
  output logic [31:0]              perf_stalls,
  output logic [31:0]              perf_loads
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
  localparam logic [1:0]         c_src_load = 2'd0;
  localparam logic [1:0]         c_src_alu  = 2'd1;
  localparam logic [1:0]         c_src_pc   = 2'd2;
  localparam logic [1:0]         c_src_none = 2'd3;
  localparam logic [1:0]         c_sel_mem  = 2'd0;
  localparam logic [1:0]         c_sel_alu  = 2'd1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0]      fifo_q [DEPTH];
  logic [AW-1:0]      fifo_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               wb_err_q, wb_err_d;

  // --------------------------------------------------------------------------
  // Hazard detection: an entry is live when its distance from the head is
  // below the current count.
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] entry_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_waw
    logic [c_ptr_w-1:0] offset;
    assign offset       = c_ptr_w'(i) - rd_ptr_q;
    assign entry_hit[i] = ({1'b0, offset} < count_q) && (fifo_q[i] == ex_rd);
  end

  logic is_wb_src;
  logic waw;
  logic fifo_empty;
  logic pop;
  logic ready_int;   // readiness ignoring reset; state logic only uses this
  logic push;
  logic ex_wb;       // accepted alu/pc retirement

  assign is_wb_src  = (ex_src == c_src_alu) || (ex_src == c_src_pc);
  assign waw        = is_wb_src && (ex_rd != '0) && (|entry_hit);
  assign fifo_empty = (count_q == '0);
  assign pop        = mem_rvalid && !fifo_empty;

  always_comb begin
    ready_int = 1'b0;
    unique case (ex_src)
      c_src_load: ready_int = (count_q < c_full) || pop;
      c_src_alu,
      c_src_pc:   ready_int = !mem_rvalid && !waw;
      c_src_none: ready_int = 1'b1;
      default:    ready_int = 1'b0;
    endcase
  end

  assign push  = ex_valid && ready_int && (ex_src == c_src_load);
  assign ex_wb = ex_valid && ready_int && is_wb_src;

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wb_err_d = wb_err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = ex_rd;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A response with nothing pending is flagged; a same-cycle push still
    // lands because the pop side is simply absent.
    if (mem_rvalid && fifo_empty) begin
      wb_err_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wb_err_q <= wb_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: combinational from current state and inputs. Memory always owns
  // the port when it responds; alu/pc never coincide with a response because
  // they are refused while mem_rvalid is high.
  // --------------------------------------------------------------------------
  always_comb begin
    ex_ready  = ready_int && !reset;
    rf_we     = 1'b0;
    wb_select = c_sel_alu;
    rf_waddr  = '0;
    if (!reset) begin
      if (pop) begin
        wb_select = c_sel_mem;
        rf_waddr  = fifo_q[rd_ptr_q];
        rf_we     = (fifo_q[rd_ptr_q] != '0);
      end else if (ex_wb) begin
        wb_select = ex_src;
        rf_waddr  = ex_rd;
        rf_we     = (ex_rd != '0);
      end
    end
  end

  assign pending = count_q;
  assign wb_err  = wb_err_q;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic [31:0] perf_loads_q,  perf_loads_d;

  always_comb begin
    perf_stalls_d = perf_stalls_q;
    perf_loads_d  = perf_loads_q;
    if (ex_valid && !ready_int) perf_stalls_d = perf_stalls_q + 32'd1;
    if (pop)                    perf_loads_d  = perf_loads_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stalls_q <= '0;
      perf_loads_q  <= '0;
    end else begin
      perf_stalls_q <= perf_stalls_d;
      perf_loads_q  <= perf_loads_d;
    end
  end

  assign perf_stalls = perf_stalls_q;
  assign perf_loads  = perf_loads_q;
`else
  assign perf_stalls = 32'd0;
  assign perf_loads  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Directed self-checking bench for wb_port_arbiter (DEPTH=4,
//             AW=5). Perf-counter checks apply when WB_ARB_PERF_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [1:0]    ex_src;
  logic [AW-1:0] ex_rd;
  logic          ex_ready;
  logic          mem_rvalid;
  logic [1:0]    wb_select;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [2:0]    pending;
  logic          wb_err;
  logic [31:0]   perf_stalls;
  logic [31:0]   perf_loads;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_src      (ex_src),
    .ex_rd       (ex_rd),
    .ex_ready    (ex_ready),
    .mem_rvalid  (mem_rvalid),
    .wb_select   (wb_select),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .pending     (pending),
    .wb_err      (wb_err),
    .perf_stalls (perf_stalls),
    .perf_loads  (perf_loads)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge, let combinational outputs settle.
  task automatic drive(input logic v, input logic [1:0] s, input logic [AW-1:0] rd, input logic rv);
    ex_valid   = v;
    ex_src     = s;
    ex_rd      = rd;
    mem_rvalid = rv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the write-port outputs in one go.
  task automatic check_port(input string tag, input logic rdy, input logic we,
                            input logic [1:0] sel, input logic [AW-1:0] wa);
    check_eq({tag, ".ready"}, 32'(ex_ready), 32'(rdy));
    check_eq({tag, ".we"},    32'(rf_we),    32'(we));
    check_eq({tag, ".sel"},   32'(wb_select), 32'(sel));
    check_eq({tag, ".waddr"}, 32'(rf_waddr), 32'(wa));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 2'd1, 5'd5, 1'b0);
    // Outputs forced while reset is high
    check_port("rst", 1'b0, 1'b0, 2'd1, 5'd0);
    check_eq("rst.pending", 32'(pending), 0);
    check_eq("rst.err", 32'(wb_err), 0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // ALU writeback, nothing pending
    drive(1'b1, 2'd1, 5'd5, 1'b0);
    check_port("alu", 1'b1, 1'b1, 2'd1, 5'd5);
    tick();

    // Idle: no-writeback source, ex_valid low
    drive(1'b0, 2'd3, 5'd12, 1'b0);
    check_port("idle", 1'b1, 1'b0, 2'd1, 5'd0);
    tick();

    // Port conflict: load rd=3 pending, response collides with pc writeback
    drive(1'b1, 2'd0, 5'd3, 1'b0);
    check_port("ld3", 1'b1, 1'b0, 2'd1, 5'd0);
    tick();
    check_eq("ld3.pending", 32'(pending), 1);
    drive(1'b1, 2'd2, 5'd7, 1'b1);
    check_port("conf", 1'b0, 1'b1, 2'd0, 5'd3);
    tick();
    check_eq("conf.pending", 32'(pending), 0);
    drive(1'b1, 2'd2, 5'd7, 1'b0);
    check_port("pc7", 1'b1, 1'b1, 2'd2, 5'd7);
    tick();

    // WAW against pending load rd=9
    drive(1'b1, 2'd0, 5'd9, 1'b0);
    tick();
    drive(1'b1, 2'd1, 5'd9, 1'b0);
    check_eq("waw.ready0", 32'(ex_ready), 0);
    tick();
    check_eq("waw.ready1", 32'(ex_ready), 0);
    drive(1'b1, 2'd1, 5'd9, 1'b1);
    check_port("waw.pop", 1'b0, 1'b1, 2'd0, 5'd9);
    tick();
    drive(1'b1, 2'd1, 5'd9, 1'b0);
    check_port("waw.acc", 1'b1, 1'b1, 2'd1, 5'd9);
    tick();

    // WAW on x0 is not a hazard
    drive(1'b1, 2'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 2'd1, 5'd0, 1'b0);
    check_port("x0alu", 1'b1, 1'b0, 2'd1, 5'd0);
    drive(1'b0, 2'd3, 5'd0, 1'b1);
    check_port("x0pop", 1'b1, 1'b0, 2'd0, 5'd0);
    tick();

    // Full FIFO: four loads then a fifth
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd0, 5'(i), 1'b0);
      tick();
    end
    check_eq("full.pending", 32'(pending), 4);
    drive(1'b1, 2'd0, 5'd6, 1'b0);
    check_eq("full.ready", 32'(ex_ready), 0);
    tick();
    check_eq("full.hold", 32'(pending), 4);
    drive(1'b1, 2'd0, 5'd6, 1'b1);
    check_port("full.pp", 1'b1, 1'b1, 2'd0, 5'd1);
    tick();
    check_eq("full.pp.pending", 32'(pending), 4);
    begin
      logic [AW-1:0] order [4];
      order[0] = 5'd2; order[1] = 5'd3; order[2] = 5'd4; order[3] = 5'd6;
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 2'd3, 5'd0, 1'b1);
        check_port($sformatf("drain%0d", i), 1'b1, 1'b1, 2'd0, order[i]);
        tick();
      end
    end
    check_eq("drain.pending", 32'(pending), 0);
    check_eq("drain.err", 32'(wb_err), 0);

    // x0 load then spurious response
    drive(1'b1, 2'd0, 5'd0, 1'b0);
    tick();
    check_eq("x0ld.pending", 32'(pending), 1);
    drive(1'b0, 2'd3, 5'd0, 1'b1);
    check_eq("x0ld.we", 32'(rf_we), 0);
    tick();
    check_eq("x0ld.pending0", 32'(pending), 0);
    drive(1'b0, 2'd3, 5'd0, 1'b1);
    check_eq("spur.we", 32'(rf_we), 0);
    tick();
    check_eq("spur.err", 32'(wb_err), 1);
    check_eq("spur.pending", 32'(pending), 0);
    drive(1'b0, 2'd3, 5'd0, 1'b0);
    tick();
    check_eq("spur.sticky", 32'(wb_err), 1);

    // Push with erroneous pop on an empty FIFO: push still lands
    drive(1'b1, 2'd0, 5'd8, 1'b1);
    check_port("epp", 1'b1, 1'b0, 2'd1, 5'd0);
    tick();
    check_eq("epp.pending", 32'(pending), 1);
    drive(1'b0, 2'd3, 5'd0, 1'b1);
    check_port("epp.pop", 1'b1, 1'b1, 2'd0, 5'd8);
    tick();
    check_eq("epp.pending0", 32'(pending), 0);

    // Async reset mid-run drops pending entries and clears the error
    drive(1'b1, 2'd0, 5'd10, 1'b0);
    tick();
    check_eq("ar.pending1", 32'(pending), 1);
    drive(1'b0, 2'd3, 5'd0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar.pending0", 32'(pending), 0);
    check_eq("ar.err0", 32'(wb_err), 0);
    tick();
    reset = 1'b0;
    #1;
    // Late response after reset
    drive(1'b0, 2'd3, 5'd0, 1'b1);
    check_eq("late.we", 32'(rf_we), 0);
    tick();
    check_eq("late.err", 32'(wb_err), 1);
    drive(1'b0, 2'd3, 5'd0, 1'b0);
    tick();

`ifdef WB_ARB_PERF_EN
    // Perf: fresh start from the reset above; two loads, three stalls,
    // two responses.
    check_eq("perf.start", perf_stalls, 0);
    drive(1'b1, 2'd0, 5'd11, 1'b0);
    tick();
    drive(1'b1, 2'd0, 5'd12, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 5'd11, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'd3, 5'd0, 1'b1);
      tick();
    end
    drive(1'b0, 2'd3, 5'd0, 1'b0);
    check_eq("perf.stalls", perf_stalls, 3);
    check_eq("perf.loads", perf_loads, 2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("perf.rst.stalls", perf_stalls, 0);
    check_eq("perf.rst.loads", perf_loads, 0);
    check_eq("perf.rst.pending", 32'(pending), 0);
    tick();
    reset = 1'b0;
    #1;
`else
    // Counters are tied off; a stall cycle must not move them.
    drive(1'b1, 2'd2, 5'd4, 1'b1);
    tick();
    drive(1'b0, 2'd3, 5'd0, 1'b0);
    check_eq("perf.off.stalls", perf_stalls, 0);
    check_eq("perf.off.loads", perf_loads, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
